// File: rtl/cordic_dispatch_if.sv
// Job/result handshake bundle between the AXI-lite bus manager (master)
// and the CORDIC job dispatcher (slave).
interface cordic_dispatch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic                  job_valid;
  logic                  job_ready;
  logic [DATA_WIDTH-1:0] job_x;
  logic [DATA_WIDTH-1:0] job_y;
  logic [DATA_WIDTH-1:0] job_z;
  logic [1:0]            job_mode;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_x;
  logic [DATA_WIDTH-1:0] res_y;
  logic [DATA_WIDTH-1:0] res_z;
  logic [TAG_WIDTH-1:0]  res_tag;

  modport master (
    output job_valid, job_x, job_y, job_z, job_mode, res_ready,
    input  job_ready, res_valid, res_x, res_y, res_z, res_tag
  );

  modport slave (
    input  job_valid, job_x, job_y, job_z, job_mode, res_ready,
    output job_ready, res_valid, res_x, res_y, res_z, res_tag
  );
endinterface

// File: rtl/cordic_dispatch.sv
// Round-robin job dispatcher for NUM_CORES CORDIC cores with tagged result FIFO.
// Optional perf counters (perf_jobs/perf_busy/perf_clear) under CORDIC_DISPATCH_PERF_EN.
module cordic_dispatch #(
  parameter int NUM_CORES  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  cordic_dispatch_if.slave                bus,
  output logic [NUM_CORES-1:0]            core_start,
  output logic [NUM_CORES*DATA_WIDTH-1:0] core_x,
  output logic [NUM_CORES*DATA_WIDTH-1:0] core_y,
  output logic [NUM_CORES*DATA_WIDTH-1:0] core_z,
  output logic [NUM_CORES*2-1:0]          core_mode,
  input  logic [NUM_CORES-1:0]            core_done,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_rx,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_ry,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_rz,
  input  logic                            irq_en,
  input  logic [$clog2(FIFO_DEPTH):0]     irq_threshold,
  output logic                            interrupt,
  output logic [$clog2(FIFO_DEPTH):0]     out_count,
  output logic                            err_spurious,
  input  logic                            err_clear
`ifdef CORDIC_DISPATCH_PERF_EN
  ,
  output logic [31:0]                     perf_jobs,
  output logic [31:0]                     perf_busy,
  input  logic                            perf_clear
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} core_state_e;

  core_state_e           state   [NUM_CORES];
  logic [TAG_WIDTH-1:0]  core_tag[NUM_CORES];
  logic [DATA_WIDTH-1:0] hold_x  [NUM_CORES];
  logic [DATA_WIDTH-1:0] hold_y  [NUM_CORES];
  logic [DATA_WIDTH-1:0] hold_z  [NUM_CORES];

  logic [DATA_WIDTH-1:0] in_x[FIFO_DEPTH], in_y[FIFO_DEPTH], in_z[FIFO_DEPTH];
  logic [1:0]            in_mode[FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  in_tag[FIFO_DEPTH];
  logic [AW-1:0]         in_wp, in_rp;
  logic [CW-1:0]         in_count;

  logic [DATA_WIDTH-1:0] out_x[FIFO_DEPTH], out_y[FIFO_DEPTH], out_z[FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  out_tag[FIFO_DEPTH];
  logic [AW-1:0]         out_wp, out_rp;

  logic [TAG_WIDTH-1:0]  tag_ctr;
  logic [IW-1:0]         rr, rr_next, scan_idx, disp_idx, col_idx;
  logic                  disp_found, col_found, dispatch, in_push;
  logic                  out_push, out_pop, spurious;
  logic [NUM_CORES-1:0]  busy_vec;

  assign bus.job_ready = (in_count != CW'(FIFO_DEPTH));
  assign in_push       = bus.job_valid && bus.job_ready;
  assign dispatch      = (in_count != '0) && disp_found;
  assign rr_next       = IW'((32'(disp_idx) + 1) % NUM_CORES);

  assign bus.res_valid = (out_count != '0);
  assign bus.res_x     = out_x[out_rp];
  assign bus.res_y     = out_y[out_rp];
  assign bus.res_z     = out_z[out_rp];
  assign bus.res_tag   = out_tag[out_rp];
  assign out_pop       = bus.res_valid && bus.res_ready;
  // Full is judged on the current count, so a same-cycle pop never makes room.
  assign out_push      = col_found && (out_count != CW'(FIFO_DEPTH));

  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      scan_idx = IW'((32'(rr) + k) % NUM_CORES);
      if (!disp_found && state[scan_idx] == IDLE) begin
        disp_found = 1'b1;
        disp_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    col_found = 1'b0;
    col_idx   = '0;
    busy_vec  = '0;
    spurious  = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      busy_vec[i] = (state[i] == BUSY);
      if (core_done[i] && state[i] != BUSY) spurious = 1'b1;
      if (!col_found && state[i] == HOLD) begin
        col_found = 1'b1;
        col_idx   = IW'(i);
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (in_push) begin
      in_x[in_wp]    <= bus.job_x;
      in_y[in_wp]    <= bus.job_y;
      in_z[in_wp]    <= bus.job_z;
      in_mode[in_wp] <= bus.job_mode;
      in_tag[in_wp]  <= tag_ctr;
    end
    if (out_push) begin
      out_x[out_wp]   <= hold_x[col_idx];
      out_y[out_wp]   <= hold_y[col_idx];
      out_z[out_wp]   <= hold_z[col_idx];
      out_tag[out_wp] <= core_tag[col_idx];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      in_wp        <= '0;
      in_rp        <= '0;
      in_count     <= '0;
      out_wp       <= '0;
      out_rp       <= '0;
      out_count    <= '0;
      tag_ctr      <= '0;
      rr           <= '0;
      core_start   <= '0;
      core_x       <= '0;
      core_y       <= '0;
      core_z       <= '0;
      core_mode    <= '0;
      interrupt    <= 1'b0;
      err_spurious <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        state[i]    <= IDLE;
        core_tag[i] <= '0;
        hold_x[i]   <= '0;
        hold_y[i]   <= '0;
        hold_z[i]   <= '0;
      end
    end else begin
      core_start <= '0;
      if (in_push) begin
        in_wp   <= in_wp + 1'b1;
        tag_ctr <= tag_ctr + 1'b1;
      end
      if (dispatch) begin
        in_rp <= in_rp + 1'b1;
        rr    <= rr_next;
      end
      in_count <= in_count + CW'(in_push) - CW'(dispatch);

      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        case (state[i])
          IDLE: if (dispatch && disp_idx == IW'(i)) begin
            state[i]                               <= BUSY;
            core_tag[i]                            <= in_tag[in_rp];
            core_start[i]                          <= 1'b1;
            core_x[i*DATA_WIDTH +: DATA_WIDTH]     <= in_x[in_rp];
            core_y[i*DATA_WIDTH +: DATA_WIDTH]     <= in_y[in_rp];
            core_z[i*DATA_WIDTH +: DATA_WIDTH]     <= in_z[in_rp];
            core_mode[i*2 +: 2]                    <= in_mode[in_rp];
          end
          BUSY: if (core_done[i]) begin
            state[i]  <= HOLD;
            hold_x[i] <= core_rx[i*DATA_WIDTH +: DATA_WIDTH];
            hold_y[i] <= core_ry[i*DATA_WIDTH +: DATA_WIDTH];
            hold_z[i] <= core_rz[i*DATA_WIDTH +: DATA_WIDTH];
          end
          HOLD: if (out_push && col_idx == IW'(i)) state[i] <= IDLE;
          default: state[i] <= IDLE;
        endcase
      end

      if (out_push) out_wp <= out_wp + 1'b1;
      if (out_pop)  out_rp <= out_rp + 1'b1;
      out_count <= out_count + CW'(out_push) - CW'(out_pop);

      interrupt <= irq_en && (irq_threshold != '0) && (out_count >= irq_threshold);

      if (spurious)       err_spurious <= 1'b1;
      else if (err_clear) err_spurious <= 1'b0;
    end
  end

`ifdef CORDIC_DISPATCH_PERF_EN
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      perf_jobs <= '0;
      perf_busy <= '0;
    end else if (perf_clear) begin
      perf_jobs <= '0;
      perf_busy <= '0;
    end else begin
      if (out_push && perf_jobs != '1) perf_jobs <= perf_jobs + 1'b1;
      if ((|busy_vec) && perf_busy != '1) perf_busy <= perf_busy + 1'b1;
    end
  end
`endif

endmodule
